// File: rtl/grn_floyd_ctrl.sv
// grn_floyd_ctrl: sweeps every initial state of an N_NODES Boolean network,
// runs Floyd tortoise/hare detection on a bank of dual-copy nodes and reports
// {init, meet, period, timeout} per state over a valid/ready handshake.
// Optional macro GRN_TIMEOUT_EN bounds each search phase by MAX_STEPS.
module grn_floyd_ctrl #(
    parameter int N_NODES   = 8,
    parameter int CNT_W     = 16,
    parameter int MAX_STEPS = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               reset_nos,
    output logic [N_NODES-1:0] init_state,
    output logic               start_s0,
    output logic               start_s1,
    input  logic [N_NODES-1:0] s0_vec,
    input  logic [N_NODES-1:0] s1_vec,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [N_NODES-1:0] res_init,
    output logic [CNT_W-1:0]   res_meet,
    output logic [CNT_W-1:0]   res_period,
    output logic               res_timeout,
    output logic               done
);
    typedef enum logic [2:0] {
        IDLE, LOAD, STEP, CHECK, PSTEP, PCHECK, REPORT, DONE
    } state_e;

    state_e             state_q;
    logic [N_NODES-1:0] cur_init_q;
    logic [CNT_W-1:0]   hstep_q, hstep_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [CNT_W-1:0]   meet_q, res_period_q;
    logic               busy_q, reset_nos_q, start_s0_q, start_s1_q;
    logic               res_valid_q, done_q;
    logic               match;

    assign match = (s0_vec == s1_vec);

`ifdef GRN_TIMEOUT_EN
    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_STEPS);
    localparam logic [CNT_W-1:0] MAX2_C = CNT_W'(2 * MAX_STEPS);
    logic timeout_q;
    // The search limit always ends a phase before the counters could wrap.
    assign hstep_d     = hstep_q + CNT_W'(1);
    assign period_d    = period_q + CNT_W'(1);
    assign res_timeout = timeout_q;
`else
    // Unbounded search: counters stick at all-ones rather than wrapping.
    assign hstep_d     = (&hstep_q) ? hstep_q : hstep_q + CNT_W'(1);
    assign period_d    = (&period_q) ? period_q : period_q + CNT_W'(1);
    assign res_timeout = 1'b0;
`endif

    assign busy       = busy_q;
    assign reset_nos  = reset_nos_q;
    assign init_state = cur_init_q;
    assign start_s0   = start_s0_q;
    assign start_s1   = start_s1_q;
    assign res_valid  = res_valid_q;
    assign res_init   = cur_init_q;
    assign res_meet   = meet_q;
    assign res_period = res_period_q;
    assign done       = done_q;

    // Sequencer; every strobe is registered on the transition into its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cur_init_q   <= '0;
            hstep_q      <= '0;
            period_q     <= '0;
            meet_q       <= '0;
            res_period_q <= '0;
            busy_q       <= 1'b0;
            reset_nos_q  <= 1'b0;
            start_s0_q   <= 1'b0;
            start_s1_q   <= 1'b0;
            res_valid_q  <= 1'b0;
            done_q       <= 1'b0;
`ifdef GRN_TIMEOUT_EN
            timeout_q    <= 1'b0;
`endif
        end else begin
            reset_nos_q <= 1'b0;
            start_s0_q  <= 1'b0;
            start_s1_q  <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cur_init_q  <= '0;
                        busy_q      <= 1'b1;
                        reset_nos_q <= 1'b1;
                        state_q     <= LOAD;
                    end
                end
                LOAD: begin
                    hstep_q    <= '0;
                    period_q   <= '0;
`ifdef GRN_TIMEOUT_EN
                    timeout_q  <= 1'b0;
`endif
                    start_s0_q <= 1'b1;
                    start_s1_q <= 1'b1;
                    state_q    <= STEP;
                end
                STEP: begin
                    hstep_q <= hstep_d;
                    state_q <= CHECK;
                end
                CHECK: begin
                    // Only an even hare count means the tortoise just moved.
                    if (hstep_q[0]) begin
                        start_s0_q <= 1'b1;
                        start_s1_q <= 1'b1;
                        state_q    <= STEP;
                    end else if (match) begin
                        meet_q     <= hstep_q >> 1;
                        start_s1_q <= 1'b1;
                        state_q    <= PSTEP;
                    end
`ifdef GRN_TIMEOUT_EN
                    else if ((hstep_q >> 1) == MAX_C) begin
                        timeout_q    <= 1'b1;
                        res_period_q <= '0;
                        meet_q       <= MAX_C;
                        res_valid_q  <= 1'b1;
                        state_q      <= REPORT;
                    end
`endif
                    else begin
                        start_s0_q <= 1'b1;
                        start_s1_q <= 1'b1;
                        state_q    <= STEP;
                    end
                end
                PSTEP: begin
                    period_q <= period_d;
                    state_q  <= PCHECK;
                end
                PCHECK: begin
                    // Tortoise is frozen on the cycle; hare walks it once.
                    if (match) begin
                        res_period_q <= period_q;
                        res_valid_q  <= 1'b1;
                        state_q      <= REPORT;
                    end
`ifdef GRN_TIMEOUT_EN
                    else if (period_q == MAX2_C) begin
                        timeout_q    <= 1'b1;
                        res_period_q <= '0;
                        res_valid_q  <= 1'b1;
                        state_q      <= REPORT;
                    end
`endif
                    else begin
                        start_s1_q <= 1'b1;
                        state_q    <= PSTEP;
                    end
                end
                REPORT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        if (&cur_init_q) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            cur_init_q  <= cur_init_q + 1'b1;
                            reset_nos_q <= 1'b1;
                            state_q     <= LOAD;
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
